// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, redirect flushes,
// data-memory freeze with timeout to a sticky error halt. Optional counters: `define HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned PERF_W = 32
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs2_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_redirect_i,
    input  logic       mem_req_i,
    input  logic       dmem_ready_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_flush_o,
    output logic       pipe_hold_o,
    output logic       mem_err_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_next_wait_cnt;

    logic w_freeze;
    logic w_load_use;
    logic w_redirect_act;
    logic w_load_use_act;

    // Hazard detection from the current state and pipeline inputs
    always_comb begin
        w_freeze   = ((r_state == ST_RUN) & mem_req_i & ~dmem_ready_i) |
                     ((r_state == ST_MEM_WAIT) & ~dmem_ready_i);
        w_load_use = ex_memread_i & (ex_rd_i != 5'd0) &
                     ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));
        // A frozen or errored pipe must replay the hazard later, so it is not acted on now.
        w_redirect_act = (r_state != ST_ERR) & ~w_freeze & ex_redirect_i;
        w_load_use_act = (r_state != ST_ERR) & ~w_freeze & ~ex_redirect_i & w_load_use;
    end

    // State and wait counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (mem_req_i & ~dmem_ready_i) begin
                    w_next_state    = ST_MEM_WAIT;
                    w_next_wait_cnt = 8'd1;
                end else begin
                    w_next_wait_cnt = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    w_next_state    = ST_RUN;
                    w_next_wait_cnt = 8'd0;
                end else if (r_wait_cnt == TIMEOUT_C) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_next_wait_cnt = r_wait_cnt + 8'd1;
                end
            end
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
            default: begin
                w_next_state    = ST_RUN;
                w_next_wait_cnt = 8'd0;
            end
        endcase
    end

    // Pipeline control outputs, priority reset > error > freeze > redirect > load-use
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        pipe_hold_o  = 1'b0;
        if (rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if ((r_state == ST_ERR) | w_freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (w_redirect_act) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (w_load_use_act) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
        end
    end

    assign mem_err_o = (r_state == ST_ERR);

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;
    logic              w_stall_evt;

    assign w_stall_evt = (r_state == ST_ERR) | w_freeze | w_load_use_act;

    // Saturating performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= {PERF_W{1'b0}};
            r_flush_cnt <= {PERF_W{1'b0}};
        end else begin
            if (w_stall_evt && (r_stall_cnt != {PERF_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_redirect_act && (r_flush_cnt != {PERF_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard cases then randomized traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int T = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] id_rs1_i = 5'd0, id_rs2_i = 5'd0, ex_rd_i = 5'd0;
    logic       id_uses_rs2_i = 1'b0, ex_memread_i = 1'b0, ex_redirect_i = 1'b0;
    logic       mem_req_i = 1'b0, dmem_ready_i = 1'b0;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o, mem_err_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(T)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .ex_redirect_i(ex_redirect_i),
        .mem_req_i(mem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_flush_o(idex_flush_o), .pipe_hold_o(pipe_hold_o), .mem_err_o(mem_err_o)
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]  outs;   // {pc_write, ifid_write, ifid_flush, idex_flush, hold, err}
        logic [31:0] stall;
        logic [31:0] flush;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: counts consecutive frozen cycles; error once more than T in a row.
    int          m_frozen = 0;
    bit          m_in_wait = 1'b0;
    bit          m_err = 1'b0;
    int unsigned m_stall = 0, m_flush = 0;
    int          n_step = 0;

    localparam logic [5:0] E_RESET  = 6'b001100;
    localparam logic [5:0] E_ERR    = 6'b000011;
    localparam logic [5:0] E_FREEZE = 6'b000010;
    localparam logic [5:0] E_REDIR  = 6'b111100;
    localparam logic [5:0] E_BUBBLE = 6'b000100;
    localparam logic [5:0] E_NORMAL = 6'b110000;

    task automatic apply(input bit rst, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u2, input bit mr, input bit redir,
                         input bit req, input bit rdy);
        exp_t e;
        bit   frz, lu;
        @(negedge clk_i);
        rst_i = rst; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = u2;
        ex_memread_i = mr; ex_redirect_i = redir; mem_req_i = req; dmem_ready_i = rdy;
        e.step = n_step;
        n_step++;
        if (rst) begin
            m_frozen = 0; m_in_wait = 1'b0; m_err = 1'b0; m_stall = 0; m_flush = 0;
            e.outs = E_RESET;
            e.stall = 32'd0; e.flush = 32'd0;
        end else begin
            e.stall = m_stall; e.flush = m_flush;
            frz = m_in_wait ? !rdy : (req && !rdy);
            lu  = mr && (rd != 5'd0) && ((rd == rs1) || (u2 && (rd == rs2)));
            if (m_err) begin
                e.outs = E_ERR;
                m_stall++;
            end else if (frz) begin
                e.outs = E_FREEZE;
                m_stall++;
                m_frozen++;
                m_in_wait = 1'b1;
                if (m_frozen > T) m_err = 1'b1;
            end else begin
                m_frozen = 0;
                m_in_wait = 1'b0;
                if (redir) begin
                    e.outs = E_REDIR;
                    m_flush++;
                end else if (lu) begin
                    e.outs = E_BUBBLE;
                    m_stall++;
                end else begin
                    e.outs = E_NORMAL;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit req, input bit rdy);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, req, rdy);
    endtask

    // Monitor: pops one expectation per cycle, sampling mid-way between edges
    initial begin
        exp_t e;
        logic [5:0] got;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o, mem_err_o};
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL outs step=%0d got=%b expected=%b", e.step, got, e.outs);
                end
`ifdef HAZARD_PERF_EN
                checks++;
                if ((stall_cnt_o !== e.stall) || (flush_cnt_o !== e.flush)) begin
                    errors++;
                    $display("FAIL perf step=%0d got=%0d/%0d expected=%0d/%0d", e.step,
                             stall_cnt_o, flush_cnt_o, e.stall, e.flush);
                end
`endif
            end
        end
    end

    initial begin
        int budget;
        logic [5:0] got;
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        // load-use on rs1, then clear
        apply(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // x0 never stalls; rs2 only matters when used
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // redirect wins over load-use
        apply(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // three-cycle memory wait with a redirect and load-use hidden by the freeze
        idle(1'b1, 1'b0);
        apply(1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b0, 1'b0);
        // zero-wait access
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        // timeout into sticky error, then reset
        for (int i = 0; i < T + 4; i++) apply(1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'(i & 1), 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // async reset asserted between edges while waiting
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        #4;
        rst_i = 1'b1;
        #1;
        got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o, mem_err_o};
        checks++;
        if (got !== E_RESET) begin
            errors++;
            $display("FAIL async_reset got=%b expected=%b", got, E_RESET);
        end
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        // randomized traffic, small register range to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 299) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
        end
        budget = 20;
        while ((exp_q.size() > 0) && (budget > 0)) begin
            @(negedge clk_i);
            budget--;
        end
        #5;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
